// File: rtl/fft_stream_adapter.sv
// fft_stream_adapter: valid/ready streaming shell around a fixed-latency,
// non-stallable FFT core with next/next_out framing. Upstream beats are
// gathered into a frame buffer and issued gap-free. Core results are captured
// into a show-ahead output FIFO whose space is reserved by credits before launch.
// Optional build macro: FFT_FRAME_CNT_EN enables the frames_in/frames_out counters.
module fft_stream_adapter #(
    parameter int SAMPLE_W  = 32,
    parameter int LANES     = 16,
    parameter int BEATS     = 1,
    parameter int OUT_DEPTH = 4,
    localparam int DATA_W   = LANES * SAMPLE_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [DATA_W-1:0] s_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_last,
    output logic              core_next,
    output logic [DATA_W-1:0] core_x,
    input  logic              core_next_out,
    input  logic [DATA_W-1:0] core_y,
    output logic              busy,
    output logic              err_overrun,
    output logic [31:0]       frames_in,
    output logic [31:0]       frames_out
);

    localparam int IDX_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int PTR_W = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CRD_W = $clog2(OUT_DEPTH + 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BEATS - 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(OUT_DEPTH - 1);

    if (OUT_DEPTH < BEATS) begin : g_depth_check
        $error("fft_stream_adapter: OUT_DEPTH must be >= BEATS");
    end

    typedef enum logic [1:0] {FILL, LAUNCH, ISSUE} state_t;

    state_t            state, state_nxt;
    logic [IDX_W-1:0]  wr_idx, iss_idx, pop_idx, cap_cnt;
    logic [DATA_W-1:0] frame_buf [BEATS];
    logic [DATA_W-1:0] fifo_mem [OUT_DEPTH];
    logic [PTR_W-1:0]  wptr, rptr;
    logic [CRD_W-1:0]  credits, occ;
    logic              cap_active;
    logic              accept, pop, push, full, push_ok;

    assign accept  = s_valid && s_ready;
    assign m_valid = (occ != '0);
    assign pop     = m_valid && m_ready;
    assign push    = cap_active;
    assign full    = (occ == CRD_W'(OUT_DEPTH));
    assign push_ok = push && (!full || pop);
    assign m_data  = fifo_mem[rptr];
    assign m_last  = m_valid && (pop_idx == IDX_LAST);
    assign busy    = (state != FILL) || (wr_idx != '0);

    // Next-state and framing outputs; launch waits until a whole frame of FIFO space is reserved.
    always_comb begin
        state_nxt = state;
        s_ready   = 1'b0;
        core_next = 1'b0;
        core_x    = '0;
        case (state)
            FILL: begin
                s_ready = 1'b1;
                if (s_valid && wr_idx == IDX_LAST) state_nxt = LAUNCH;
            end
            LAUNCH: begin
                if (credits >= CRD_W'(BEATS)) begin
                    core_next = 1'b1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                core_x = frame_buf[iss_idx];
                if (iss_idx == IDX_LAST) state_nxt = FILL;
            end
            default: state_nxt = FILL;
        endcase
    end

    // State register plus fill and issue beat counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= FILL;
            wr_idx  <= '0;
            iss_idx <= '0;
        end else begin
            state <= state_nxt;
            if (accept) wr_idx <= (wr_idx == IDX_LAST) ? '0 : wr_idx + 1'b1;
            if (state == ISSUE) iss_idx <= (iss_idx == IDX_LAST) ? '0 : iss_idx + 1'b1;
        end
    end

    // Frame buffer storage; data only, no reset needed.
    always_ff @(posedge clk) begin
        if (accept) frame_buf[wr_idx] <= s_data;
    end

    // Capture window, FIFO pointers, occupancy, credits and the sticky overrun flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cap_active  <= 1'b0;
            cap_cnt     <= '0;
            wptr        <= '0;
            rptr        <= '0;
            occ         <= '0;
            pop_idx     <= '0;
            credits     <= CRD_W'(OUT_DEPTH);
            err_overrun <= 1'b0;
        end else begin
            if (core_next_out) begin
                cap_active <= 1'b1;
                cap_cnt    <= '0;
            end else if (cap_active) begin
                if (cap_cnt == IDX_LAST) cap_active <= 1'b0;
                cap_cnt <= (cap_cnt == IDX_LAST) ? '0 : cap_cnt + 1'b1;
            end
            if ((core_next_out && cap_active) || (push && !push_ok)) err_overrun <= 1'b1;
            if (push_ok) wptr <= (wptr == PTR_LAST) ? '0 : wptr + 1'b1;
            if (pop) begin
                rptr    <= (rptr == PTR_LAST) ? '0 : rptr + 1'b1;
                pop_idx <= (pop_idx == IDX_LAST) ? '0 : pop_idx + 1'b1;
            end
            occ     <= occ + CRD_W'(push_ok) - CRD_W'(pop);
            credits <= credits + CRD_W'(pop) - (core_next ? CRD_W'(BEATS) : '0);
        end
    end

    // Output FIFO storage; written unconditionally while capturing unless full.
    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wptr] <= core_y;
    end

`ifdef FFT_FRAME_CNT_EN
    // Frame counters: launches and fully popped frames, free-running modulo 2^32.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frames_in  <= '0;
            frames_out <= '0;
        end else begin
            if (core_next) frames_in <= frames_in + 32'd1;
            if (pop && m_last) frames_out <= frames_out + 32'd1;
        end
    end
`else
    assign frames_in  = '0;
    assign frames_out = '0;
`endif

endmodule

// File: tb/tb_fft_stream_adapter.sv
// Directed testbench for fft_stream_adapter: three instances
// (BEATS=1/DEPTH=4, BEATS=2/DEPTH=4, BEATS=1/DEPTH=2) each driving a
// 3-cycle delay echo core model. Honours FFT_FRAME_CNT_EN for counter checks.
module tb_fft_stream_adapter;

    localparam int SW = 8;
    localparam int LN = 4;
    localparam int DW = SW * LN;
`ifdef FFT_FRAME_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    // Instance A: BEATS=1, OUT_DEPTH=4
    logic a_s_valid = 0, a_s_ready, a_m_valid, a_m_ready = 1, a_m_last, a_core_next, a_core_next_out, a_busy, a_err;
    logic [DW-1:0] a_s_data = '0, a_m_data, a_core_x, a_core_y;
    logic [31:0] a_fin, a_fout;
    // Instance B: BEATS=2, OUT_DEPTH=4
    logic b_s_valid = 0, b_s_ready, b_m_valid, b_m_ready = 1, b_m_last, b_core_next, b_core_next_out, b_busy, b_err;
    logic b_inj = 0;
    logic [DW-1:0] b_s_data = '0, b_m_data, b_core_x, b_core_y;
    logic [31:0] b_fin, b_fout;
    // Instance C: BEATS=1, OUT_DEPTH=2
    logic c_s_valid = 0, c_s_ready, c_m_valid, c_m_ready = 0, c_m_last, c_core_next, c_core_next_out, c_busy, c_err;
    logic [DW-1:0] c_s_data = '0, c_m_data, c_core_x, c_core_y;
    logic [31:0] c_fin, c_fout;

    fft_stream_adapter #(.SAMPLE_W(SW), .LANES(LN), .BEATS(1), .OUT_DEPTH(4)) u_a (
        .clk(clk), .reset(reset), .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
        .m_valid(a_m_valid), .m_ready(a_m_ready), .m_data(a_m_data), .m_last(a_m_last),
        .core_next(a_core_next), .core_x(a_core_x), .core_next_out(a_core_next_out), .core_y(a_core_y),
        .busy(a_busy), .err_overrun(a_err), .frames_in(a_fin), .frames_out(a_fout));

    fft_stream_adapter #(.SAMPLE_W(SW), .LANES(LN), .BEATS(2), .OUT_DEPTH(4)) u_b (
        .clk(clk), .reset(reset), .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
        .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data), .m_last(b_m_last),
        .core_next(b_core_next), .core_x(b_core_x), .core_next_out(b_core_next_out), .core_y(b_core_y),
        .busy(b_busy), .err_overrun(b_err), .frames_in(b_fin), .frames_out(b_fout));

    fft_stream_adapter #(.SAMPLE_W(SW), .LANES(LN), .BEATS(1), .OUT_DEPTH(2)) u_c (
        .clk(clk), .reset(reset), .s_valid(c_s_valid), .s_ready(c_s_ready), .s_data(c_s_data),
        .m_valid(c_m_valid), .m_ready(c_m_ready), .m_data(c_m_data), .m_last(c_m_last),
        .core_next(c_core_next), .core_x(c_core_x), .core_next_out(c_core_next_out), .core_y(c_core_y),
        .busy(c_busy), .err_overrun(c_err), .frames_in(c_fin), .frames_out(c_fout));

    // Core models: 3-cycle delay echo of next and x
    logic [2:0]    a_nd = '0, b_nd = '0, c_nd = '0;
    logic [DW-1:0] a_yd [3] = '{default: '0};
    logic [DW-1:0] b_yd [3] = '{default: '0};
    logic [DW-1:0] c_yd [3] = '{default: '0};
    always @(posedge clk) begin
        a_nd <= {a_nd[1:0], a_core_next};
        b_nd <= {b_nd[1:0], b_core_next};
        c_nd <= {c_nd[1:0], c_core_next};
        a_yd[0] <= a_core_x; a_yd[1] <= a_yd[0]; a_yd[2] <= a_yd[1];
        b_yd[0] <= b_core_x; b_yd[1] <= b_yd[0]; b_yd[2] <= b_yd[1];
        c_yd[0] <= c_core_x; c_yd[1] <= c_yd[0]; c_yd[2] <= c_yd[1];
    end
    assign a_core_next_out = a_nd[2];
    assign b_core_next_out = b_nd[2] | b_inj;
    assign c_core_next_out = c_nd[2];
    assign a_core_y = a_yd[2];
    assign b_core_y = b_yd[2];
    assign c_core_y = c_yd[2];

    // Output monitors: popped beats as {last, data}, launch and pop counters
    logic [DW:0] a_outq[$];
    logic [DW:0] b_outq[$];
    logic [DW:0] c_outq[$];
    int b_nlaunch = 0, b_pops = 0, b_pops_at_launch = 0, c_nlaunch = 0;
    always @(posedge clk) begin
        if (a_m_valid && a_m_ready) a_outq.push_back({a_m_last, a_m_data});
        if (b_m_valid && b_m_ready) b_outq.push_back({b_m_last, b_m_data});
        if (c_m_valid && c_m_ready) c_outq.push_back({c_m_last, c_m_data});
        if (b_core_next) begin
            b_nlaunch <= b_nlaunch + 1;
            b_pops_at_launch <= b_pops;
        end
        if (b_m_valid && b_m_ready) b_pops <= b_pops + 1;
        if (c_core_next) c_nlaunch <= c_nlaunch + 1;
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic timeout_fail(input string tag);
        n_vec++;
        n_err++;
        $display("FAIL %s: timed out waiting on DUT", tag);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic a_send(input logic [DW-1:0] d);
        logic acc;
        a_s_valid = 1'b1; a_s_data = d;
        for (int n = 0; n < 50; n++) begin
            #1; acc = a_s_ready;
            cyc();
            if (acc) begin a_s_valid = 1'b0; return; end
        end
        a_s_valid = 1'b0;
        timeout_fail("a_send");
    endtask

    task automatic b_send(input logic [DW-1:0] d);
        logic acc;
        b_s_valid = 1'b1; b_s_data = d;
        for (int n = 0; n < 50; n++) begin
            #1; acc = b_s_ready;
            cyc();
            if (acc) begin b_s_valid = 1'b0; return; end
        end
        b_s_valid = 1'b0;
        timeout_fail("b_send");
    endtask

    task automatic c_send(input logic [DW-1:0] d);
        logic acc;
        c_s_valid = 1'b1; c_s_data = d;
        for (int n = 0; n < 50; n++) begin
            #1; acc = c_s_ready;
            cyc();
            if (acc) begin c_s_valid = 1'b0; return; end
        end
        c_s_valid = 1'b0;
        timeout_fail("c_send");
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] exp_b [6];
        int base, pbase;

        // Reset values
        #3;
        check_val("rst_s_ready", a_s_ready, 1);
        check_val("rst_m_valid", a_m_valid, 0);
        check_val("rst_m_last", a_m_last, 0);
        check_val("rst_core_next", a_core_next, 0);
        check_val("rst_core_x", a_core_x, 0);
        check_val("rst_busy", a_busy, 0);
        check_val("rst_err", a_err, 0);
        check_val("rst_fin", a_fin, 0);
        check_val("rst_fout", a_fout, 0);
        check_val("rst_b_m_valid", b_m_valid, 0);
        cyc(); cyc(); cyc();
        reset = 1'b1;
        cyc();

        // T1: BEATS=1 echo, exact launch timing
        a_s_valid = 1'b1; a_s_data = 32'h03020100;
        #2 check_val("a_fill_ready", a_s_ready, 1);
        cyc(); a_s_valid = 1'b0;
        #2 check_val("a_core_next_t1", a_core_next, 1);
        check_val("a_s_ready_t1", a_s_ready, 0);
        check_val("a_busy_t1", a_busy, 1);
        cyc();
        #2 check_val("a_core_x_t2", a_core_x, 32'h03020100);
        check_val("a_core_next_t2", a_core_next, 0);
        cyc();
        #2 check_val("a_s_ready_t3", a_s_ready, 1);
        check_val("a_core_x_t3", a_core_x, 0);
        a_send(32'hDEADBEEF);
        a_send(32'h00FF7F80);
        for (int n = 0; n < 40 && a_outq.size() < 3; n++) cyc();
        check_val("a_out_cnt", a_outq.size(), 3);
        if (a_outq.size() >= 3) begin
            check_val("a_out0", a_outq[0], {1'b1, 32'h03020100});
            check_val("a_out1", a_outq[1], {1'b1, 32'hDEADBEEF});
            check_val("a_out2", a_outq[2], {1'b1, 32'h00FF7F80});
        end
        check_val("a_err_end", a_err, 0);
        check_val("a_fin_end", a_fin, CNT_EN ? 3 : 0);
        check_val("a_fout_end", a_fout, CNT_EN ? 3 : 0);

        // T2: BEATS=2 with a 3-cycle upstream gap, gap-free issue
        b_s_valid = 1'b1; b_s_data = 32'h11223344;
        #2 check_val("b_fill_ready", b_s_ready, 1);
        cyc(); b_s_valid = 1'b0;
        #2 check_val("b_next_gap", b_core_next, 0);
        check_val("b_busy_gap", b_busy, 1);
        cyc(); cyc(); cyc();
        b_s_valid = 1'b1; b_s_data = 32'h55667788;
        #2 check_val("b_next_before", b_core_next, 0);
        cyc(); b_s_valid = 1'b0;
        #2 check_val("b_next_pulse", b_core_next, 1);
        check_val("b_ready_launch", b_s_ready, 0);
        cyc();
        #2 check_val("b_core_x_a", b_core_x, 32'h11223344);
        check_val("b_next_low", b_core_next, 0);
        cyc();
        #2 check_val("b_core_x_b", b_core_x, 32'h55667788);
        cyc();
        #2 check_val("b_core_x_idle", b_core_x, 0);
        check_val("b_ready_back", b_s_ready, 1);
        for (int n = 0; n < 40 && b_outq.size() < 2; n++) cyc();
        check_val("b_out_cnt", b_outq.size(), 2);
        if (b_outq.size() >= 2) begin
            check_val("b_out0", b_outq[0], {1'b0, 32'h11223344});
            check_val("b_out1", b_outq[1], {1'b1, 32'h55667788});
        end

        // T3: backpressure, third frame held for credits
        b_m_ready = 1'b0;
        b_outq.delete();
        base = b_nlaunch; pbase = b_pops;
        for (int i = 0; i < 6; i++) begin
            exp_b[i] = 32'hA0000000 + 32'(i * 17 + 1);
            b_send(exp_b[i]);
        end
        for (int n = 0; n < 10; n++) cyc();
        #2 check_val("b_hold_ready", b_s_ready, 0);
        check_val("b_hold_next", b_core_next, 0);
        check_val("b_hold_launches", b_nlaunch - base, 2);
        check_val("b_hold_m_valid", b_m_valid, 1);
        check_val("b_hold_m_data", b_m_data, exp_b[0]);
        check_val("b_hold_m_last", b_m_last, 0);
        check_val("b_hold_busy", b_busy, 1);
        b_m_ready = 1'b1;
        for (int n = 0; n < 60 && (b_nlaunch - base) < 3; n++) cyc();
        check_val("b_third_launch", b_nlaunch - base, 3);
        check_val("b_pops_at_launch", b_pops_at_launch - pbase, 2);
        for (int n = 0; n < 60 && b_outq.size() < 6; n++) cyc();
        check_val("b_bp_cnt", b_outq.size(), 6);
        for (int i = 0; i < 6 && i < b_outq.size(); i++)
            check_val($sformatf("b_bp_out%0d", i), b_outq[i], {(i % 2 == 1), exp_b[i]});
        check_val("b_bp_err", b_err, 0);

        // T4: OUT_DEPTH=2, pops racing credit reservation
        fork
            begin
                for (int i = 0; i < 10; i++) c_send(32'hC0DE0000 + 32'(i));
            end
            begin
                for (int k = 0; k < 120; k++) begin
                    c_m_ready = (k % 3 != 0);
                    cyc();
                end
            end
        join
        c_m_ready = 1'b1;
        for (int n = 0; n < 60 && c_outq.size() < 10; n++) cyc();
        check_val("c_out_cnt", c_outq.size(), 10);
        for (int i = 0; i < 10 && i < c_outq.size(); i++)
            check_val($sformatf("c_out%0d", i), c_outq[i], {1'b1, 32'hC0DE0000 + 32'(i)});
        check_val("c_launches", c_nlaunch, 10);
        check_val("c_err", c_err, 0);
        check_val("c_fout", c_fout, CNT_EN ? 10 : 0);

        // T5: asynchronous reset in the middle of ISSUE
        b_send(32'h0BADF00D);
        b_send(32'h0CAFE000);
        cyc();
        #2 check_val("b_pre_rst_x", b_core_x, 32'h0BADF00D);
        #1 reset = 1'b0;
        #1 check_val("arst_s_ready", b_s_ready, 1);
        check_val("arst_m_valid", b_m_valid, 0);
        check_val("arst_m_last", b_m_last, 0);
        check_val("arst_core_next", b_core_next, 0);
        check_val("arst_core_x", b_core_x, 0);
        check_val("arst_busy", b_busy, 0);
        check_val("arst_err", b_err, 0);
        check_val("arst_fin", b_fin, 0);
        for (int n = 0; n < 5; n++) cyc();
        reset = 1'b1;
        cyc();
        b_outq.delete();
        b_send(32'h13579BDF);
        b_send(32'h2468ACE0);
        for (int n = 0; n < 40 && b_outq.size() < 2; n++) cyc();
        check_val("b_post_cnt", b_outq.size(), 2);
        if (b_outq.size() >= 2) begin
            check_val("b_post0", b_outq[0], {1'b0, 32'h13579BDF});
            check_val("b_post1", b_outq[1], {1'b1, 32'h2468ACE0});
        end
        check_val("b_post_fin", b_fin, CNT_EN ? 1 : 0);
        check_val("b_post_fout", b_fout, CNT_EN ? 1 : 0);
        check_val("b_post_err", b_err, 0);

        // T6: double core_next_out sets sticky overrun
        b_inj = 1'b1;
        cyc(); cyc();
        b_inj = 1'b0;
        for (int n = 0; n < 6; n++) cyc();
        #2 check_val("b_overrun_set", b_err, 1);
        for (int n = 0; n < 5; n++) cyc();
        #2 check_val("b_overrun_sticky", b_err, 1);
        #1 reset = 1'b0;
        #1 check_val("b_overrun_clr", b_err, 0);
        cyc();
        reset = 1'b1;
        cyc();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
